vga_mem_arbiter: RTL

Shares the single-port video memory between the CPU data port and the VGA scan-out path. Prefetches packed pixel words into a small FIFO, driven by the H/V position counters of the 1280x1024@60 Hz sync generator. Serialises those words into one pixel per 108 MHz pixel clock, aligned with the registered blank/sync outputs. All CPU accesses to video memory go through this block.

---
 rtl/vga_pkg.sv | 11 +
 rtl/pixel_fifo.sv | 42 ++++
 rtl/vga_mem_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: 1280x1024@60 video timing constants and the memory arbiter grant encoding.
package vga_pkg;
    localparam int H_VIS        = 1280;
    localparam int V_VIS        = 1024;
    localparam int H_TOTAL      = 1688;
    localparam int V_TOTAL      = 1066;
    localparam int PIX_PER_WORD = 4;
    localparam int FRAME_WORDS  = H_VIS * V_VIS / PIX_PER_WORD;

    typedef enum logic [1:0] {GNT_NONE, GNT_DISP, GNT_CPU} gnt_e;
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: small synchronous prefetch FIFO; flush has priority over push/pop.
module pixel_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        flush,
    input  logic [DATA_W-1:0]           wdata,
    output logic [DATA_W-1:0]           rdata,
    output logic [$clog2(FIFO_DEPTH):0] occ,
    output logic                        empty
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;

    assign rdata = mem[rd_ptr];
    assign empty = occ == '0;

    always_ff @(posedge clk)
        if (push && !flush) mem[wr_ptr] <= wdata;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
endmodule

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares the single-port video memory between the CPU and the
// VGA scan-out prefetcher, and serialises prefetched words into one pixel per clock.
module vga_mem_arbiter
    import vga_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                PIX_W      = 8,
    parameter int                ADDR_W     = 19,
    parameter int                H_VIS      = vga_pkg::H_VIS,
    parameter int                V_VIS      = vga_pkg::V_VIS,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [10:0]       H,
    input  logic [10:0]       V,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [PIX_W-1:0]  pixel,
    output logic              underrun
);
    localparam int PPW     = DATA_W / PIX_W;
    localparam int FRAME_W = H_VIS * V_VIS / PPW;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int OCC_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int SEL_W   = $clog2(PPW);

    gnt_e              gnt;
    logic              visible, reload, eligible, urgent, inflight, push, pop, empty;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W:0]    pending;
    logic [ADDR_W-1:0] fetch_addr;
    logic [CNT_W-1:0]  fetch_cnt;
    logic [DATA_W-1:0] head;
    logic [SEL_W-1:0]  sel;

    assign visible  = int'(H) < H_VIS && int'(V) < V_VIS;
    assign reload   = int'(V) == V_VIS && H == '0;
    assign pending  = {1'b0, occ} + (OCC_W + 1)'(inflight);
    // No display fetch in the reload cycle: its address would belong to the old frame.
    assign eligible = !reload && int'(fetch_cnt) < FRAME_W && int'(pending) < FIFO_DEPTH;
    assign urgent   = eligible && int'(pending) <= 1;

    always_comb
        gnt = !rst_n ? GNT_NONE : urgent ? GNT_DISP : cpu_req ? GNT_CPU : eligible ? GNT_DISP : GNT_NONE;

    assign cpu_gnt   = gnt == GNT_CPU;
    assign mem_en    = gnt != GNT_NONE;
    assign mem_we    = cpu_gnt && cpu_we;
    assign mem_addr  = cpu_gnt ? cpu_addr : fetch_addr;
    assign mem_wdata = cpu_wdata;
    assign cpu_rdata = cpu_rvalid ? mem_rdata : '0;

    assign sel  = H[SEL_W-1:0];
    assign push = inflight && !reload;
    assign pop  = visible && !empty && &sel;

    pixel_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (reload),
        .wdata (mem_rdata),
        .rdata (head),
        .occ   (occ),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            inflight   <= 1'b0;
            cpu_rvalid <= 1'b0;
            fetch_addr <= BASE_ADDR;
            fetch_cnt  <= '0;
            pixel      <= '0;
            underrun   <= 1'b0;
        end else begin
            inflight   <= gnt == GNT_DISP;
            cpu_rvalid <= cpu_gnt && !cpu_we;
            pixel      <= visible && !empty ? head[sel*PIX_W +: PIX_W] : '0;
            if (reload) begin
                fetch_addr <= BASE_ADDR;
                fetch_cnt  <= '0;
                underrun   <= 1'b0;
            end else begin
                if (gnt == GNT_DISP) begin
                    fetch_addr <= fetch_addr + 1'b1;
                    fetch_cnt  <= fetch_cnt + 1'b1;
                end
                if (visible && empty) underrun <= 1'b1;
            end
        end
endmodule
